inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage of the single-issue processor. Produces the instruction stream that the decoder turns into register-file controls (write enable, I-type flag, operation, register address).
- Owns the program counter and a programmable branch-target lookup table (LUT).
- Drives a synchronous instruction memory with 1-cycle read latency.
- Hands instructions to decode over a valid/ready handshake through a 2-entry buffer.

Parameters:
- PW, 10, program counter / instruction address width
- IW, 9, instruction width
- LA, 4, LUT index width (2**LA targets)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  pulse: begin fetching at StartPC
- StartPC  in  PW  initial PC
- Halt  in  1  pulse from decode: stop fetching
- BranchEn  in  1  pulse from decode: redirect to LUT[BrIdx]
- BrIdx  in  LA  LUT index for redirect
- LutWe  in  1  LUT write enable
- LutWaddr  in  LA  LUT write index
- LutWdata  in  PW  LUT write data
- ImemRe  out  1  instruction memory read strobe
- ImemAddr  out  PW  instruction memory address
- ImemRdata  in  IW  read data, valid the cycle after ImemRe
- InstValid  out  1  buffer head valid
- InstReady  in  1  decode accepts head
- InstOut  out  IW  head instruction
- InstPC  out  PW  PC of head instruction
- Done  out  1  high while HALTED

Behaviour:
- Reset (async, Reset=0): state IDLE; PC=0; all LUT entries=0; buffer empty; inflight=0.
  - Outputs: ImemRe=0, ImemAddr=0, InstValid=0, InstOut=0, InstPC=0, Done=0.
  - Reset mid-run discards the buffer and any in-flight read immediately.
- States: IDLE, RUN, HALTED.
  - IDLE --Start--> RUN: PC=StartPC.
  - RUN --Halt--> HALTED: flush buffer, kill in-flight read, Done=1 from the next cycle.
  - HALTED --Start--> RUN: PC=StartPC, Done=0.
  - Start while in RUN is ignored.
- Issue rule (cycle t):
  - ImemRe=1 iff state==RUN && !Halt && !BranchEn && (count + inflight - pop) < 2, where pop = InstValid & InstReady.
  - ImemAddr=PC; on issue PC<=PC+1, wrapping from 2**PW-1 to 0.
  - ImemAddr holds the last PC when not issuing.
- Response: ImemRdata sampled at the end of the cycle after issue; pushed with its PC unless killed. InstValid rises the following cycle.
- Latency: Start in cycle 0 -> ImemRe in cycle 1 -> data in cycle 2 -> InstValid/InstOut in cycle 3.
  - With InstReady held high: 1 instruction/cycle sustained, no bubbles.
- Buffer: 2-entry FIFO.
  - InstOut/InstPC show the head and stay stable while InstValid && !InstReady.
  - Push and pop may occur in the same cycle.
  - Overflow is impossible by the issue rule; a push into a full buffer is a design error (assertion).
- Redirect (BranchEn in RUN):
  - A handshake completing in the same cycle stands, since the branch instruction itself is consumed.
  - All other buffer entries are flushed; the in-flight read is killed.
  - PC<=LUT[BrIdx]; the next issue is the following cycle.
- Simultaneous events:
  - Halt beats BranchEn.
  - BranchEn or Halt outside RUN is ignored.
  - LutWe to the same index being read by BranchEn: redirect uses the old value; the new value is visible next cycle.
  - LUT writes are accepted in every state.

Test Plan:
- Reset low mid-stream with 2 entries buffered -> immediately InstValid=0, ImemRe=0, Done=0; after release, state IDLE, no fetch until Start.
- Start, StartPC=0x010, InstReady=1, imem[i]=i[8:0] -> ImemRe in cycle 1; InstValid in cycle 3 with InstPC=0x010; then 0x011, 0x012… one per cycle.
- InstReady=0 for 5 cycles after first valid -> at most 2 entries buffered; ImemRe stays 0 while full; InstOut stable; on release, PCs resume in order with no duplicates or drops.
- LutWe idx 3 = 0x200, then BranchEn BrIdx=3 while buffer full and a read is in flight -> stale entries dropped; next InstPC=0x200.
- PC wrap: StartPC=0x3FE, PW=10 -> InstPC sequence 0x3FE, 0x3FF, 0x000.
- Halt and BranchEn in the same cycle -> HALTED, Done=1 next cycle, no further ImemRe; a later Start with StartPC=0x005 resumes and clears Done.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC and branch-target LUT, 1-cycle-latency imem interface,
// and a 2-entry valid/ready buffer toward decode.
module inst_fetch #(
  parameter int PW = 10,
  parameter int IW = 9,
  parameter int LA = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [PW-1:0] StartPC,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic [LA-1:0] BrIdx,
  input  logic          LutWe,
  input  logic [LA-1:0] LutWaddr,
  input  logic [PW-1:0] LutWdata,
  output logic          ImemRe,
  output logic [PW-1:0] ImemAddr,
  input  logic [IW-1:0] ImemRdata,
  output logic          InstValid,
  input  logic          InstReady,
  output logic [IW-1:0] InstOut,
  output logic [PW-1:0] InstPC,
  output logic          Done
);

  localparam int DEPTH = 2 ** LA;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] lut_q [DEPTH];
  logic [PW-1:0] lut_d [DEPTH];
  logic [1:0]    cnt_q, cnt_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] ifpc_q, ifpc_d;
  logic [IW-1:0] e0_ins_q, e0_ins_d, e1_ins_q, e1_ins_d;
  logic [PW-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;

  logic          run_s, kill_s, pop_s, push_s, issue_s, ovf_s;
  logic [2:0]    occ_s;
  logic [1:0]    cnt_mid_s;

  // Issue decision: occupancy counts the in-flight read so the buffer can never overflow.
  always_comb begin
    run_s   = (state_q == S_RUN);
    kill_s  = run_s && (Halt || BranchEn);
    pop_s   = (cnt_q != 2'd0) && InstReady;
    push_s  = inflight_q && !kill_s;
    occ_s   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s = run_s && !Halt && !BranchEn && (occ_s < 3'd2);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = StartPC;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (Halt) begin
          state_d = S_HALT;
        end else if (BranchEn) begin
          pc_d = lut_q[BrIdx];
        end else if (issue_s) begin
          pc_d = pc_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Buffer update order: pop, then flush on redirect/halt, then push the returning read.
  always_comb begin
    e0_ins_d = e0_ins_q;
    e0_pc_d  = e0_pc_q;
    e1_ins_d = e1_ins_q;
    e1_pc_d  = e1_pc_q;
    if (pop_s) begin
      e0_ins_d  = e1_ins_q;
      e0_pc_d   = e1_pc_q;
      cnt_mid_s = cnt_q - 2'd1;
    end else begin
      cnt_mid_s = cnt_q;
    end
    if (kill_s) begin
      cnt_mid_s = 2'd0;
    end else begin
      cnt_mid_s = cnt_mid_s;
    end
    ovf_s = push_s && (cnt_mid_s == 2'd2);
    if (push_s) begin
      if (cnt_mid_s == 2'd0) begin
        e0_ins_d = ImemRdata;
        e0_pc_d  = ifpc_q;
      end else begin
        e1_ins_d = ImemRdata;
        e1_pc_d  = ifpc_q;
      end
      cnt_d = cnt_mid_s + 2'd1;
    end else begin
      cnt_d = cnt_mid_s;
    end
    inflight_d = issue_s;
    ifpc_d     = issue_s ? pc_q : ifpc_q;
  end

  // Redirect reads the pre-write LUT contents, so a same-index write lands next cycle.
  always_comb begin
    lut_d = lut_q;
    if (LutWe) begin
      lut_d[LutWaddr] = LutWdata;
    end else begin
      lut_d = lut_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      ifpc_q     <= '0;
      e0_ins_q   <= '0;
      e0_pc_q    <= '0;
      e1_ins_q   <= '0;
      e1_pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      ifpc_q     <= ifpc_d;
      e0_ins_q   <= e0_ins_d;
      e0_pc_q    <= e0_pc_d;
      e1_ins_q   <= e1_ins_d;
      e1_pc_q    <= e1_pc_d;
      lut_q      <= lut_d;
    end
  end

  assign ImemRe    = issue_s;
  assign ImemAddr  = pc_q;
  assign InstValid = (cnt_q != 2'd0);
  assign InstOut   = e0_ins_q;
  assign InstPC    = e0_pc_q;
  assign Done      = (state_q == S_HALT);

  inst_fetch_chk u_chk (
    .clk   (Clk),
    .rst_n (Reset),
    .ovf   (ovf_s)
  );

endmodule

// Checker: a push into a full buffer means the issue rule was broken.
module inst_fetch_chk (
  input logic clk,
  input logic rst_n,
  input logic ovf
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !ovf)
    else $error("inst_fetch buffer overflow");

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: latency, backpressure, redirect, halt, PC wrap, reset.
module tb_inst_fetch;

  logic       Clk, Reset, Start, Halt, BranchEn, LutWe, InstReady;
  logic [9:0] StartPC, LutWdata, ImemAddr, InstPC, pcx;
  logic [3:0] BrIdx, LutWaddr;
  logic [8:0] ImemRdata, InstOut;
  logic       ImemRe, InstValid, Done;
  int         n_chk, n_bad;

  inst_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartPC(StartPC), .Halt(Halt),
    .BranchEn(BranchEn), .BrIdx(BrIdx), .LutWe(LutWe), .LutWaddr(LutWaddr),
    .LutWdata(LutWdata), .ImemRe(ImemRe), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata),
    .InstValid(InstValid), .InstReady(InstReady), .InstOut(InstOut), .InstPC(InstPC),
    .Done(Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // imem[i] = i[8:0], one-cycle read latency
  always @(posedge Clk) begin
    if (ImemRe) ImemRdata <= ImemAddr[8:0];
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance one cycle; pulses drop automatically
  task automatic nc();
    @(posedge Clk);
    #2;
    Start = 1'b0; Halt = 1'b0; BranchEn = 1'b0; LutWe = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    Reset = 1'b0; Start = 1'b0; StartPC = '0; Halt = 1'b0; BranchEn = 1'b0;
    BrIdx = '0; LutWe = 1'b0; LutWaddr = '0; LutWdata = '0; InstReady = 1'b0;
    ImemRdata = '0;
    #3;
    chk_val("rst_re", ImemRe, 0);
    chk_val("rst_addr", ImemAddr, 0);
    chk_val("rst_valid", InstValid, 0);
    chk_val("rst_out", InstOut, 0);
    chk_val("rst_pc", InstPC, 0);
    chk_val("rst_done", Done, 0);
    nc(); Reset = 1'b1;

    // cycle 0: Start at 0x010
    nc(); Start = 1'b1; StartPC = 10'h010; InstReady = 1'b1; #1;
    chk_val("c0_re", ImemRe, 0);
    nc(); #1;
    chk_val("c1_re", ImemRe, 1);
    chk_val("c1_addr", ImemAddr, 10'h010);
    nc(); #1;
    chk_val("c2_addr", ImemAddr, 10'h011);
    chk_val("c2_valid", InstValid, 0);
    for (int i = 0; i < 3; i++) begin
      nc(); #1;
      chk_val("stream_valid", InstValid, 1);
      chk_val("stream_pc", InstPC, 10'h010 + i);
      chk_val("stream_out", InstOut, 9'h010 + i);
    end

    // cycles 6..10: backpressure, head holds at 0x013
    for (int i = 0; i < 5; i++) begin
      nc(); InstReady = 1'b0; #1;
      chk_val("bp_re", ImemRe, 0);
      chk_val("bp_valid", InstValid, 1);
      chk_val("bp_pc", InstPC, 10'h013);
      chk_val("bp_out", InstOut, 9'h013);
    end
    // cycles 11..14: resume in order
    for (int i = 0; i < 4; i++) begin
      nc(); InstReady = 1'b1; #1;
      chk_val("res_valid", InstValid, 1);
      chk_val("res_pc", InstPC, 10'h013 + i);
      chk_val("res_re", ImemRe, 1);
    end

    // cycle 15: program LUT[3]; cycle 16: redirect with a read in flight
    nc(); LutWe = 1'b1; LutWaddr = 4'd3; LutWdata = 10'h200;
    nc(); InstReady = 1'b0; BranchEn = 1'b1; BrIdx = 4'd3; #1;
    chk_val("br_re", ImemRe, 0);
    chk_val("br_pc", InstPC, 10'h018);
    nc(); InstReady = 1'b1; #1;
    chk_val("br1_valid", InstValid, 0);
    chk_val("br1_re", ImemRe, 1);
    chk_val("br1_addr", ImemAddr, 10'h200);
    nc(); #1;
    chk_val("br2_valid", InstValid, 0);
    chk_val("br2_addr", ImemAddr, 10'h201);
    nc(); #1;
    chk_val("br3_valid", InstValid, 1);
    chk_val("br3_pc", InstPC, 10'h200);
    chk_val("br3_out", InstOut, 9'h000);

    // cycle 20: redirect and same-index LUT write: old target used
    nc(); BranchEn = 1'b1; BrIdx = 4'd3; LutWe = 1'b1; LutWaddr = 4'd3; LutWdata = 10'h300; #1;
    chk_val("brw_pc", InstPC, 10'h201);
    chk_val("brw_re", ImemRe, 0);
    nc(); #1;
    chk_val("brw_addr", ImemAddr, 10'h200);
    chk_val("brw_re2", ImemRe, 1);
    chk_val("brw_valid", InstValid, 0);

    // cycle 22: Halt beats BranchEn
    nc(); Halt = 1'b1; BranchEn = 1'b1; BrIdx = 4'd3; #1;
    chk_val("hb_re", ImemRe, 0);
    chk_val("hb_done", Done, 0);
    nc(); #1;
    chk_val("h1_done", Done, 1);
    chk_val("h1_re", ImemRe, 0);
    chk_val("h1_valid", InstValid, 0);
    nc(); #1;
    chk_val("h2_done", Done, 1);
    chk_val("h2_re", ImemRe, 0);
    chk_val("h2_valid", InstValid, 0);
    chk_val("h2_addr", ImemAddr, 10'h201);

    // cycle 25: restart at 0x005
    nc(); Start = 1'b1; StartPC = 10'h005; #1;
    chk_val("rs_done", Done, 1);
    nc(); #1;
    chk_val("rs1_done", Done, 0);
    chk_val("rs1_re", ImemRe, 1);
    chk_val("rs1_addr", ImemAddr, 10'h005);
    nc();
    nc(); Start = 1'b1; StartPC = 10'h100; #1;
    chk_val("rs3_valid", InstValid, 1);
    chk_val("rs3_pc", InstPC, 10'h005);
    // cycle 29: Start in RUN was ignored
    nc(); Halt = 1'b1; #1;
    chk_val("ign_addr", ImemAddr, 10'h008);
    chk_val("ign_pc", InstPC, 10'h006);
    chk_val("ign_re", ImemRe, 0);

    // cycle 30: PC wrap from 0x3FE
    nc(); Start = 1'b1; StartPC = 10'h3FE; #1;
    chk_val("wr_done", Done, 1);
    nc(); #1;
    chk_val("wr1_done", Done, 0);
    chk_val("wr1_addr", ImemAddr, 10'h3FE);
    chk_val("wr1_re", ImemRe, 1);
    nc();
    for (int i = 0; i < 3; i++) begin
      nc(); #1;
      pcx = 10'h3FE + i[9:0];
      chk_val("wrap_valid", InstValid, 1);
      chk_val("wrap_pc", InstPC, pcx);
      chk_val("wrap_out", InstOut, pcx[8:0]);
    end

    // cycles 36..37: fill buffer, then async reset mid-stream
    nc(); InstReady = 1'b0; #1;
    chk_val("fill_pc", InstPC, 10'h001);
    nc(); #1;
    chk_val("full_valid", InstValid, 1);
    chk_val("full_pc", InstPC, 10'h001);
    chk_val("full_re", ImemRe, 0);
    Reset = 1'b0; #1;
    chk_val("ar_valid", InstValid, 0);
    chk_val("ar_re", ImemRe, 0);
    chk_val("ar_done", Done, 0);
    chk_val("ar_pc", InstPC, 0);
    nc(); Reset = 1'b1; InstReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nc(); #1;
      chk_val("idle_re", ImemRe, 0);
      chk_val("idle_valid", InstValid, 0);
      chk_val("idle_done", Done, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
